// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard, load-use bubble, branch flush, mem-busy freeze (optional stats: PIPE_HAZARD_STAT_EN).
// Latency: stall/flush combinational in the same cycle; forward selects registered for the instruction entering EX.
// Backpressure: mem_busy freezes IF/ID/EX and holds scoreboard; a branch seen while frozen is replayed after the freeze.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_reg1_addr,
    input  logic       id_reg1_used,
    input  logic [4:0] id_reg2_addr,
    input  logic       id_reg2_used,
    input  logic [4:0] id_wb_reg_addr,
    input  logic       id_is_load,
    input  logic       ex_do_branch,
    input  logic       mem_busy,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       flush_if2id,
    output logic       flush_id2ex,
    output logic       reg1_forward,
    output logic       reg1_fwd_src,
    output logic       reg2_forward,
    output logic       reg2_fwd_src,
    output logic       mem_timeout
`ifdef PIPE_HAZARD_STAT_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_flush_count,
    output logic [31:0] stat_lu_count
`endif
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);

    state_t           state;
    logic             pending_flush;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic [4:0]       ex_dst;
    logic [4:0]       mem_dst;
    logic             ex_ld;

    logic r1_hit_ex;
    logic r1_hit_mem;
    logic r2_hit_ex;
    logic r2_hit_mem;
    logic freeze;
    logic do_flush;
    logic load_use;

    // Register 0 is hardwired, so an address of 0 never counts as a hit.
    always_comb begin
        r1_hit_ex    = id_reg1_used && (id_reg1_addr != 5'd0) && (id_reg1_addr == ex_dst);
        r1_hit_mem   = id_reg1_used && (id_reg1_addr != 5'd0) && (id_reg1_addr == mem_dst);
        r2_hit_ex    = id_reg2_used && (id_reg2_addr != 5'd0) && (id_reg2_addr == ex_dst);
        r2_hit_mem   = id_reg2_used && (id_reg2_addr != 5'd0) && (id_reg2_addr == mem_dst);
        freeze       = mem_busy;
        do_flush     = !mem_busy && (ex_do_branch || pending_flush);
        load_use     = !mem_busy && !do_flush && id_valid && ex_ld && (r1_hit_ex || r2_hit_ex);
        wait_cnt_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_if2id = 1'b0;
        flush_id2ex = 1'b0;
        if (!rst) begin
            stall_if    = freeze || load_use;
            stall_id    = freeze || load_use;
            stall_ex    = freeze;
            flush_if2id = do_flush;
            flush_id2ex = do_flush || load_use;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            pending_flush <= 1'b0;
            wait_cnt      <= '0;
            ex_dst        <= 5'd0;
            ex_ld         <= 1'b0;
            mem_dst       <= 5'd0;
            reg1_forward  <= 1'b0;
            reg1_fwd_src  <= 1'b0;
            reg2_forward  <= 1'b0;
            reg2_fwd_src  <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == WAIT_MAX) begin
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc == WAIT_MAX) begin
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            // A branch reported during a freeze is remembered and flushed once memory releases.
            if (mem_busy && ex_do_branch) begin
                pending_flush <= 1'b1;
            end

            if (!mem_busy) begin
                if (do_flush) begin
                    mem_dst       <= ex_dst;
                    ex_dst        <= 5'd0;
                    ex_ld         <= 1'b0;
                    reg1_forward  <= 1'b0;
                    reg1_fwd_src  <= 1'b0;
                    reg2_forward  <= 1'b0;
                    reg2_fwd_src  <= 1'b0;
                    pending_flush <= 1'b0;
                end else if (load_use) begin
                    mem_dst      <= ex_dst;
                    ex_dst       <= 5'd0;
                    ex_ld        <= 1'b0;
                    reg1_forward <= 1'b0;
                    reg1_fwd_src <= 1'b0;
                    reg2_forward <= 1'b0;
                    reg2_fwd_src <= 1'b0;
                end else begin
                    mem_dst      <= ex_dst;
                    ex_dst       <= id_valid ? id_wb_reg_addr : 5'd0;
                    ex_ld        <= id_valid && id_is_load;
                    // The younger (EX) producer wins when both stages hold the same destination.
                    reg1_forward <= id_valid && (r1_hit_ex || r1_hit_mem);
                    reg1_fwd_src <= id_valid && !r1_hit_ex && r1_hit_mem;
                    reg2_forward <= id_valid && (r2_hit_ex || r2_hit_mem);
                    reg2_fwd_src <= id_valid && !r2_hit_ex && r2_hit_mem;
                end
            end
        end
    end

`ifdef PIPE_HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= 32'd0;
            stat_flush_count  <= 32'd0;
            stat_lu_count     <= 32'd0;
        end else begin
            if (stall_id) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            if (do_flush) begin
                stat_flush_count <= stat_flush_count + 32'd1;
            end
            if (load_use) begin
                stat_lu_count <= stat_lu_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch flush, mem freeze, timeout, r0 and reset.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_reg1_addr;
    logic       id_reg1_used;
    logic [4:0] id_reg2_addr;
    logic       id_reg2_used;
    logic [4:0] id_wb_reg_addr;
    logic       id_is_load;
    logic       ex_do_branch;
    logic       mem_busy;
    logic       stall_if, stall_id, stall_ex, flush_if2id, flush_id2ex;
    logic       reg1_forward, reg1_fwd_src, reg2_forward, reg2_fwd_src;
    logic       mem_timeout;
`ifdef PIPE_HAZARD_STAT_EN
    logic [31:0] stat_stall_cycles, stat_flush_count, stat_lu_count;
`endif

    logic [4:0] ctl;
    logic [3:0] fwd;
    int tests = 0;
    int fails = 0;

    assign ctl = {stall_if, stall_id, stall_ex, flush_if2id, flush_id2ex};
    assign fwd = {reg1_forward, reg1_fwd_src, reg2_forward, reg2_fwd_src};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_reg1_addr   (id_reg1_addr),
        .id_reg1_used   (id_reg1_used),
        .id_reg2_addr   (id_reg2_addr),
        .id_reg2_used   (id_reg2_used),
        .id_wb_reg_addr (id_wb_reg_addr),
        .id_is_load     (id_is_load),
        .ex_do_branch   (ex_do_branch),
        .mem_busy       (mem_busy),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .flush_if2id    (flush_if2id),
        .flush_id2ex    (flush_id2ex),
        .reg1_forward   (reg1_forward),
        .reg1_fwd_src   (reg1_fwd_src),
        .reg2_forward   (reg2_forward),
        .reg2_fwd_src   (reg2_fwd_src),
        .mem_timeout    (mem_timeout)
`ifdef PIPE_HAZARD_STAT_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flush_count  (stat_flush_count),
        .stat_lu_count     (stat_lu_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2,
                          input logic [4:0] wb, input logic ld);
        id_valid       = v;
        id_reg1_addr   = a1;
        id_reg1_used   = u1;
        id_reg2_addr   = a2;
        id_reg2_used   = u2;
        id_wb_reg_addr = wb;
        id_is_load     = ld;
    endtask

    // Inputs change 1 time unit after the edge; combinational outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag, input logic [4:0] exp_ctl, input logic [3:0] exp_fwd);
        #4;
        chk({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        tick();
        chk({tag, "_fwd"}, 32'(fwd), 32'(exp_fwd));
    endtask

    initial begin
        rst = 1'b1;
        ex_do_branch = 1'b1;
        mem_busy = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        #1;
        // reset forces stall/flush to 0 even with busy/branch asserted
        cycle("rst0", 5'b00000, 4'b0000);
        cycle("rst1", 5'b00000, 4'b0000);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        ex_do_branch = 1'b0;
        mem_busy = 1'b0;

        // back-to-back ALU ops
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
        cycle("alu_r3", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0);
        cycle("alu_r4", 5'b00000, 4'b1010);
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0);
        cycle("alu_r5", 5'b00000, 4'b1110);
        set_id(1'b1, 5'd5, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0);
        cycle("unused_src", 5'b00000, 4'b0000);

        // load r2 then use r2 on operand 1
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        cycle("ld_r2", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
        cycle("lu1_bubble", 5'b11001, 4'b0000);
        cycle("lu1_issue", 5'b00000, 4'b1100);
`ifdef PIPE_HAZARD_STAT_EN
        chk("stat_lu_1", stat_lu_count, 32'd1);
        chk("stat_stall_1", stat_stall_cycles, 32'd1);
`endif

        // load r7 then use r7 on operand 2
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle("ld_r7", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
        cycle("lu2_bubble", 5'b11001, 4'b0000);
        cycle("lu2_issue", 5'b00000, 4'b0011);

        // taken branch flushes ID instruction that would have forwarded from r8
        ex_do_branch = 1'b1;
        set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);
        cycle("br_flush", 5'b00011, 4'b0000);
        ex_do_branch = 1'b0;
        set_id(1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
        cycle("br_after", 5'b00000, 4'b0011);

        // branch outranks a concurrent load-use
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cycle("ld_r3", 5'b00000, 4'b0000);
        ex_do_branch = 1'b1;
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("br_over_lu", 5'b00011, 4'b0000);
        ex_do_branch = 1'b0;
`ifdef PIPE_HAZARD_STAT_EN
        chk("stat_flush_2", stat_flush_count, 32'd2);
`endif

        // mem_busy 3 cycles with branch on the first; forward regs hold during freeze
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
        cycle("pre_busy", 5'b00000, 4'b1100);
        mem_busy = 1'b1;
        ex_do_branch = 1'b1;
        set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0);
        cycle("busy1", 5'b11100, 4'b1100);
        ex_do_branch = 1'b0;
        cycle("busy2", 5'b11100, 4'b1100);
        cycle("busy3", 5'b11100, 4'b1100);
        chk("busy3_timeout", 32'(mem_timeout), 32'd0);
        mem_busy = 1'b0;
        cycle("busy_release_flush", 5'b00011, 4'b0000);
        set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("post_flush", 5'b00000, 4'b1100);

        // timeout: 10 busy cycles against a limit of 4
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle($sformatf("to_busy%0d", i), 5'b11100, 4'b1100);
            chk($sformatf("to_flag%0d", i), 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        mem_busy = 1'b0;
        cycle("to_release", 5'b00000, 4'b0000);
        chk("to_sticky1", 32'(mem_timeout), 32'd1);
        cycle("to_idle", 5'b00000, 4'b0000);
        chk("to_sticky2", 32'(mem_timeout), 32'd1);

        // register 0 never forwards nor stalls
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle("wr_r0", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle("rd_r0", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        cycle("ld_r0", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 1'b0);
        cycle("use_r0", 5'b00000, 4'b0000);

        // reset in the middle of a load-use stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        cycle("ld_r4", 5'b00000, 4'b0000);
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0);
        #4;
        chk("lu_rst_pre", 32'(ctl), 32'b11001);
        rst = 1'b1;
        #2;
        chk("lu_rst_forced", 32'(ctl), 32'd0);
        tick();
        chk("lu_rst_fwd", 32'(fwd), 32'd0);
        chk("lu_rst_timeout", 32'(mem_timeout), 32'd0);
`ifdef PIPE_HAZARD_STAT_EN
        chk("lu_rst_stats", stat_stall_cycles | stat_flush_count | stat_lu_count, 32'd0);
`endif
        rst = 1'b0;
        cycle("after_rst", 5'b00000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
